traffic_phase_ctrl: RTL

- Parametrised N-phase traffic-light controller. It generalises the two-street green/yellow/red FSM to NUM_PHASES approaches.
- Integrates the per-state duration timers, so no external g_end/y_end/r_end is needed. Adds pedestrian walk requests and a night flashing-yellow mode.
- Sits between the 1 Hz tick generator and the lamp drivers / 7-segment countdown display.

---
 rtl/traffic_phase_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase round-robin traffic-light controller with
// integrated green/yellow/all-red timers, pedestrian walk requests and a
// night flashing-yellow mode. All outputs are registered.
module traffic_phase_ctrl #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PH_W       = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [CNT_W-1:0]        g_time,
    input  logic [CNT_W-1:0]        y_time,
    input  logic [CNT_W-1:0]        r_time,
    input  logic                    night_mode,
    input  logic [NUM_PHASES-1:0]   ped_req,
    output logic [3*NUM_PHASES-1:0] lamp,
    output logic [NUM_PHASES-1:0]   pri_lamp,
    output logic [NUM_PHASES-1:0]   walk,
    output logic [PH_W-1:0]         phase_idx,
    output logic [1:0]              state_o,
    output logic [CNT_W-1:0]        cnt_o
);

    localparam int unsigned     LAMP_W   = 3 * NUM_PHASES;
    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(NUM_PHASES - 1);
    localparam logic [2:0]      L_GREEN  = 3'b100;
    localparam logic [2:0]      L_YELLOW = 3'b010;
    localparam logic [2:0]      L_RED    = 3'b001;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10,
        ST_FLASH  = 2'b11
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,    w_cnt_nxt;
    logic [PH_W-1:0]       r_phase,  w_phase_nxt;
    logic [NUM_PHASES-1:0] r_pend,   w_pend_nxt;
    logic [NUM_PHASES-1:0] r_walk,   w_walk_nxt;
    logic                  r_flash,  w_flash_nxt;
    logic [LAMP_W-1:0]     r_lamp,   w_lamp_nxt;
    logic [NUM_PHASES-1:0] r_pri,    w_pri_nxt;
    logic                  w_expire;
    logic                  w_green_entry;

    // A zero duration behaves like a single tick.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] dur);
        return (dur == '0) ? '0 : dur - CNT_W'(1);
    endfunction

    // Next-state, timer, pedestrian and lamp decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_phase_nxt   = r_phase;
        w_flash_nxt   = r_flash;
        w_walk_nxt    = r_walk;
        w_pend_nxt    = r_pend | ped_req;
        w_green_entry = 1'b0;
        w_expire      = tick && (r_cnt == '0);
        w_lamp_nxt    = '0;
        w_pri_nxt     = '0;

        if (tick) begin
            case (r_state)
                ST_GREEN: begin
                    if (w_expire) begin
                        w_state_nxt = ST_YELLOW;
                        w_cnt_nxt   = load_cnt(y_time);
                        w_walk_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (w_expire) begin
                        w_state_nxt = ST_ALLRED;
                        w_cnt_nxt   = load_cnt(r_time);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_ALLRED: begin
                    if (w_expire) begin
                        if (night_mode) begin
                            w_state_nxt = ST_FLASH;
                            w_cnt_nxt   = '0;
                            w_flash_nxt = 1'b0;
                        end else begin
                            w_state_nxt   = ST_GREEN;
                            w_phase_nxt   = (r_phase == LAST_PH) ? '0 : r_phase + PH_W'(1);
                            w_cnt_nxt     = load_cnt(g_time);
                            w_green_entry = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_FLASH: begin
                    w_flash_nxt = ~r_flash;
                    if (!night_mode) begin
                        // Park on the last phase so phase 0 is served next.
                        w_state_nxt = ST_ALLRED;
                        w_cnt_nxt   = load_cnt(r_time);
                        w_phase_nxt = LAST_PH;
                    end
                end
                default: ;
            endcase
        end

        // Serve the pending walk request of the phase entering green;
        // a request on this same clock stays pending.
        if (w_green_entry) begin
            w_walk_nxt = '0;
            for (int i = 0; i < int'(NUM_PHASES); i++) begin
                if (PH_W'(i) == w_phase_nxt) begin
                    w_walk_nxt[i] = r_pend[i];
                    w_pend_nxt[i] = ped_req[i];
                end
            end
        end

        for (int i = 0; i < int'(NUM_PHASES); i++) begin
            case (w_state_nxt)
                ST_GREEN:  w_lamp_nxt[3*i +: 3] = (PH_W'(i) == w_phase_nxt) ? L_GREEN  : L_RED;
                ST_YELLOW: w_lamp_nxt[3*i +: 3] = (PH_W'(i) == w_phase_nxt) ? L_YELLOW : L_RED;
                ST_FLASH:  w_lamp_nxt[3*i +: 3] = {1'b0, w_flash_nxt, 1'b0};
                default:   w_lamp_nxt[3*i +: 3] = L_RED;
            endcase
            w_pri_nxt[i] = w_lamp_nxt[3*i];
        end
    end

    // State, timer and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ALLRED;
            r_cnt   <= '0;
            r_phase <= LAST_PH;
            r_pend  <= '0;
            r_walk  <= '0;
            r_flash <= 1'b0;
            r_lamp  <= {NUM_PHASES{L_RED}};
            r_pri   <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_pend  <= w_pend_nxt;
            r_walk  <= w_walk_nxt;
            r_flash <= w_flash_nxt;
            r_lamp  <= w_lamp_nxt;
            r_pri   <= w_pri_nxt;
        end
    end

    assign lamp      = r_lamp;
    assign pri_lamp  = r_pri;
    assign walk      = r_walk;
    assign phase_idx = r_phase;
    assign state_o   = r_state;
    assign cnt_o     = r_cnt;

endmodule
